// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - vertical timing constants and framebuffer arbiter state for vga_frame_ctrl
package vga_pkg;

  localparam int unsigned LINES       = 521;
  localparam int unsigned VSYNC_END   = 2;
  localparam int unsigned VDISP_START = 31;
  localparam int unsigned VDISP_END   = 511;
  localparam int unsigned ROW_REPEAT  = 5;
  localparam int unsigned FB_AW       = 14;
  localparam int unsigned LINE_W      = 10;
  localparam int unsigned ROW_W       = 7;
  localparam int unsigned COL_W       = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_vcount.sv
// rtl/vga_vcount.sv - line counter and vertical sync/display/row generation
module vga_vcount
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             line_start_i,
  output logic             vga_vsync_o,
  output logic [ROW_W-1:0] vpixel_o,
  output logic             vdisp_o,
  output logic             frame_start_o
);

  localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(LINES - 1);
  localparam logic [LINE_W-1:0] VSYNC_LIMIT = LINE_W'(VSYNC_END);
  localparam logic [LINE_W-1:0] DISP_FIRST  = LINE_W'(VDISP_START);
  localparam logic [LINE_W-1:0] DISP_LIMIT  = LINE_W'(VDISP_END);
  localparam logic [2:0]        SUB_LAST    = 3'(ROW_REPEAT - 1);

  logic [LINE_W-1:0] line_q, line_d, nxt_line;
  logic [2:0]        sub_q, sub_d;
  logic [ROW_W-1:0]  vpixel_q, vpixel_d;
  logic              vsync_q, vsync_d;
  logic              vdisp_q, vdisp_d;
  logic              fs_q, fs_d;
  logic              en_q;
  logic              nxt_disp;

  // en_q gates line_start so a pulse coinciding with enable rising is dropped
  always_comb begin
    line_d   = line_q;
    sub_d    = sub_q;
    vpixel_d = vpixel_q;
    vsync_d  = vsync_q;
    vdisp_d  = vdisp_q;
    fs_d     = 1'b0;
    nxt_line = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
    nxt_disp = (nxt_line >= DISP_FIRST) && (nxt_line < DISP_LIMIT);
    if (!enable_i) begin
      line_d   = '0;
      sub_d    = '0;
      vpixel_d = '0;
      vsync_d  = 1'b1;
      vdisp_d  = 1'b0;
    end else if (line_start_i && en_q) begin
      line_d  = nxt_line;
      vsync_d = (nxt_line >= VSYNC_LIMIT);
      vdisp_d = nxt_disp;
      fs_d    = (nxt_line == '0);
      if (nxt_line == DISP_FIRST || !nxt_disp) begin
        sub_d    = '0;
        vpixel_d = '0;
      end else if (sub_q == SUB_LAST) begin
        sub_d    = '0;
        vpixel_d = vpixel_q + ROW_W'(1);
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q   <= '0;
      sub_q    <= '0;
      vpixel_q <= '0;
      vsync_q  <= 1'b1;
      vdisp_q  <= 1'b0;
      fs_q     <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      line_q   <= line_d;
      sub_q    <= sub_d;
      vpixel_q <= vpixel_d;
      vsync_q  <= vsync_d;
      vdisp_q  <= vdisp_d;
      fs_q     <= fs_d;
      en_q     <= enable_i;
    end
  end

  assign vga_vsync_o   = vsync_q;
  assign vpixel_o      = vpixel_q;
  assign vdisp_o       = vdisp_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - vertical timing plus framebuffer read/write arbitration
module vga_frame_ctrl
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             line_start,
  input  logic             hdisp,
  input  logic [COL_W-1:0] hpixel,
  input  logic             wr_req,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [2:0]       wr_data,
  output logic             wr_ack,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [2:0]       fb_wdata,
  output logic             vga_vsync,
  output logic [ROW_W-1:0] vpixel,
  output logic             vdisp,
  output logic             frame_start
);

  arb_state_e       state_q, state_d;
  logic             we_q, we_d;
  logic             ack_q, ack_d;
  logic [FB_AW-1:0] addr_q, addr_d;
  logic [2:0]       wdata_q, wdata_d;
  logic             act;

  vga_vcount u_vcount (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .line_start_i (line_start),
    .vga_vsync_o  (vga_vsync),
    .vpixel_o     (vpixel),
    .vdisp_o      (vdisp),
    .frame_start_o(frame_start)
  );

  assign act = enable & hdisp & vdisp;

  // Display reads own the bus; writes only start from IDLE and then sit out two cycles
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (act) begin
      addr_d = {vpixel, hpixel};
    end
    case (state_q)
      IDLE: begin
        if (!act && wr_req) begin
          we_d    = 1'b1;
          ack_d   = 1'b1;
          addr_d  = wr_addr;
          wdata_d = wr_data;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign fb_we    = we_q;
  assign wr_ack   = ack_q;
  assign fb_addr  = addr_q;
  assign fb_wdata = wdata_q;

endmodule
